// File: rtl/reg_writeback_pkg.sv
// ============================================================================
// wb_pkg : shared encodings for the register-file write-back unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_writeback_if.sv
// ============================================================================
// reg_writeback_if : result, load-response and register-file write bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_writeback_if #(
   parameter int XLEN = 32
);
   logic            wb_valid_i;
   logic [4:0]      rd_i;
   logic [1:0]      wb_sel_i;
   logic [XLEN-1:0] alu_res_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] imm_i;
   logic [2:0]      load_funct3_i;
   logic [1:0]      load_addr_lo_i;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;
   logic            busy_o;
   logic            rf_we_o;
   logic [4:0]      rf_waddr_o;
   logic [XLEN-1:0] rf_wdata_o;
   logic            err_o;

   modport master (
      output wb_valid_i, rd_i, wb_sel_i, alu_res_i, pc_i, imm_i,
             load_funct3_i, load_addr_lo_i, mem_rvalid_i, mem_rdata_i,
      input  busy_o, rf_we_o, rf_waddr_o, rf_wdata_o, err_o
   );

   modport slave (
      input  wb_valid_i, rd_i, wb_sel_i, alu_res_i, pc_i, imm_i,
             load_funct3_i, load_addr_lo_i, mem_rvalid_i, mem_rdata_i,
      output busy_o, rf_we_o, rf_waddr_o, rf_wdata_o, err_o
   );
endinterface

`default_nettype wire

// File: rtl/reg_writeback_load_align.sv
// ============================================================================
// load_align : selects and extends the loaded byte/half/word, flags bad loads
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic [2:0]      funct3_i,
   input  wire logic [1:0]      addr_lo_i,
   input  wire logic [XLEN-1:0] rdata_i,
   output logic      [XLEN-1:0] data_o,
   output logic                 err_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign w_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      data_o = rdata_i;
      err_o  = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: data_o = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            data_o = {{(XLEN-16){w_half[15]}}, w_half};
            err_o  = addr_lo_i[0];
         end
         F3_LHU: begin
            data_o = {{(XLEN-16){1'b0}}, w_half};
            err_o  = addr_lo_i[0];
         end
         F3_LW:  err_o = (addr_lo_i != 2'b00);
         default: err_o = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// reg_writeback : turns accepted results into one registered register-file
//                 write, waiting for load data with a bounded timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_writeback #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  wire logic       clk_i,
   input  wire logic       rst_i,
   reg_writeback_if.slave  bus
);
   import wb_pkg::*;

   localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   wb_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      lo_q, lo_d;
   logic            we_q, we_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            err_q, err_d;

   logic [2:0]      w_al_f3;
   logic [1:0]      w_al_lo;
   logic [XLEN-1:0] w_al_data;
   logic            w_al_err;
   logic [XLEN-1:0] w_res;

   // One aligner serves both jobs: error check on the incoming load while
   // idle, extension of the latched load while waiting for data.
   assign w_al_f3 = (state_q == S_IDLE) ? bus.load_funct3_i  : f3_q;
   assign w_al_lo = (state_q == S_IDLE) ? bus.load_addr_lo_i : lo_q;

   load_align #(.XLEN(XLEN)) u_align (
      .funct3_i  (w_al_f3),
      .addr_lo_i (w_al_lo),
      .rdata_i   (bus.mem_rdata_i),
      .data_o    (w_al_data),
      .err_o     (w_al_err)
   );

   always_comb begin
      case (wb_sel_e'(bus.wb_sel_i))
         WB_PC4:  w_res = bus.pc_i + XLEN'(4);
         WB_IMM:  w_res = bus.imm_i;
         default: w_res = bus.alu_res_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      f3_d    = f3_q;
      lo_d    = lo_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.wb_valid_i) begin
               if (wb_sel_e'(bus.wb_sel_i) == WB_MEM) begin
                  if (w_al_err) begin
                     err_d = 1'b1;
                  end else begin
                     rd_d    = bus.rd_i;
                     f3_d    = bus.load_funct3_i;
                     lo_d    = bus.load_addr_lo_i;
                     cnt_d   = '0;
                     state_d = S_WAIT_MEM;
                  end
               end else if (bus.rd_i != 5'd0) begin
                  we_d    = 1'b1;
                  waddr_d = bus.rd_i;
                  wdata_d = w_res;
               end
            end
         end
         S_WAIT_MEM: begin
            // Data arriving on the final counter value still wins.
            if (bus.mem_rvalid_i) begin
               if (rd_q != 5'd0) begin
                  we_d    = 1'b1;
                  waddr_d = rd_q;
                  wdata_d = w_al_data;
               end
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         f3_q    <= '0;
         lo_q    <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         f3_q    <= f3_d;
         lo_q    <= lo_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy_o     = (state_q == S_WAIT_MEM);
   assign bus.rf_we_o    = we_q;
   assign bus.rf_waddr_o = waddr_q;
   assign bus.rf_wdata_o = wdata_q;
   assign bus.err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// tb_reg_writeback : directed stimulus against a per-cycle expectation table
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_writeback;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 16;
   localparam int NC      = 512;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   reg_writeback_if #(.XLEN(XLEN)) bus();

   reg_writeback #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs per cycle; untouched cycles mean "idle, nothing happens".
   bit        exp_we   [NC];
   bit        exp_busy [NC];
   bit        exp_err  [NC];
   bit [4:0]  exp_addr [NC];
   bit [31:0] exp_data [NC];
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
      end
   endtask

   function automatic logic [31:0] load_result(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * lo)) % 256;
      h = (w >> (16 * (lo / 2))) % 65536;
      case (f3)
         3'b000:  return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
         3'b001:  return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
         3'b100:  return 32'(b);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic bit load_legal(input logic [2:0] f3, input logic [1:0] lo);
      if (f3 == 3'b000 || f3 == 3'b100) return 1'b1;
      if (f3 == 3'b001 || f3 == 3'b101) return (lo % 2) == 0;
      if (f3 == 3'b010) return lo == 0;
      return 1'b0;
   endfunction

   task automatic exp_write(input int c, input logic [4:0] a, input logic [31:0] d);
      if (c < NC) begin
         exp_we[c]   = 1'b1;
         exp_addr[c] = a;
         exp_data[c] = d;
      end
   endtask

   task automatic set_busy(input int c);
      if (c < NC) exp_busy[c] = 1'b1;
   endtask

   task automatic set_err(input int c);
      if (c < NC) exp_err[c] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_addr = '0;
         m_data = '0;
      end
      if (cyc < NC) begin
         if (exp_we[cyc]) begin
            m_addr = exp_addr[cyc];
            m_data = exp_data[cyc];
         end
         chk("rf_we",    32'(bus.rf_we_o),    32'(exp_we[cyc]));
         chk("busy",     32'(bus.busy_o),     32'(exp_busy[cyc]));
         chk("err",      32'(bus.err_o),      32'(exp_err[cyc]));
         chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(m_addr));
         chk("rf_wdata", bus.rf_wdata_o,      m_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_op(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
      int k;
      logic [31:0] res;
      k = cyc;
      bus.wb_valid_i = 1'b1;
      bus.wb_sel_i   = sel;
      bus.rd_i       = rd;
      bus.alu_res_i  = (sel == 2'd0) ? val : 32'hA5A5_0001;
      bus.pc_i       = (sel == 2'd2) ? val : 32'hA5A5_0002;
      bus.imm_i      = (sel == 2'd3) ? val : 32'hA5A5_0003;
      res = (sel == 2'd2) ? val + 32'd4 : val;
      if (rd != 5'd0) exp_write(k + 1, rd, res);
      step();
      bus.wb_valid_i = 1'b0;
   endtask

   // d = cycles after acceptance at which rvalid arrives; d<1 means never.
   task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                          input int d, input logic [31:0] word, input bit noise);
      int k, n, wend;
      bit hit;
      k = cyc;
      bus.wb_valid_i     = 1'b1;
      bus.wb_sel_i       = 2'd1;
      bus.rd_i           = rd;
      bus.load_funct3_i  = f3;
      bus.load_addr_lo_i = lo;
      if (!load_legal(f3, lo)) begin
         set_err(k + 1);
         step();
         bus.wb_valid_i = 1'b0;
         return;
      end
      hit  = (d >= 1 && d <= TIMEOUT);
      wend = hit ? d : TIMEOUT;
      n    = (d > TIMEOUT) ? d : wend;
      for (int i = 1; i <= wend; i++) set_busy(k + i);
      if (hit) begin
         if (rd != 5'd0) exp_write(k + d + 1, rd, load_result(f3, lo, word));
      end else begin
         set_err(k + TIMEOUT + 1);
      end
      step();
      for (int i = 1; i <= n; i++) begin
         bus.wb_valid_i   = noise && (i <= wend);
         bus.wb_sel_i     = 2'd0;
         bus.rd_i         = 5'd9;
         bus.alu_res_i    = 32'hBAD0_0000 + 32'(i);
         bus.mem_rvalid_i = (i == d);
         bus.mem_rdata_i  = (i == d) ? word : 32'h5A5A_0000 + 32'(i);
         step();
      end
      bus.wb_valid_i   = 1'b0;
      bus.mem_rvalid_i = 1'b0;
   endtask

   initial begin
      int k;
      bus.wb_valid_i     = 1'b0;
      bus.rd_i           = '0;
      bus.wb_sel_i       = '0;
      bus.alu_res_i      = '0;
      bus.pc_i           = '0;
      bus.imm_i          = '0;
      bus.load_funct3_i  = '0;
      bus.load_addr_lo_i = '0;
      bus.mem_rvalid_i   = 1'b0;
      bus.mem_rdata_i    = '0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      chk("model_lb",  load_result(3'b000, 2'd3, 32'h80AA_BBCC), 32'hFFFF_FF80);
      chk("model_lbu", load_result(3'b100, 2'd3, 32'h80AA_BBCC), 32'h0000_0080);
      chk("model_lh",  load_result(3'b001, 2'd2, 32'h80AA_BBCC), 32'hFFFF_80AA);
      chk("model_lhu", load_result(3'b101, 2'd0, 32'h80AA_BBCC), 32'h0000_BBCC);

      wb_op(2'd0, 5'd5, 32'h1234_5678);
      @(negedge clk);
      chk("alu_lit_we",   32'(bus.rf_we_o),    32'd1);
      chk("alu_lit_data", bus.rf_wdata_o,      32'h1234_5678);
      step();

      wb_op(2'd2, 5'd1, 32'hFFFF_FFFC);
      wb_op(2'd3, 5'd31, 32'hDEAD_BEEF);
      wb_op(2'd0, 5'd2, 32'h0000_0001);
      wb_op(2'd3, 5'd0, 32'hFFFF_FFFF);
      step();

      do_load(3'b000, 2'd3, 5'd7, 2, 32'h80AA_BBCC, 1'b0);
      @(negedge clk);
      chk("lb_lit_data", bus.rf_wdata_o,      32'hFFFF_FF80);
      chk("lb_lit_addr", 32'(bus.rf_waddr_o), 32'd7);
      step();
      do_load(3'b100, 2'd3, 5'd7, 2, 32'h80AA_BBCC, 1'b0);
      do_load(3'b001, 2'd2, 5'd8, 1, 32'h80AA_BBCC, 1'b0);
      do_load(3'b101, 2'd0, 5'd9, 3, 32'h80AA_BBCC, 1'b1);
      do_load(3'b010, 2'd0, 5'd0, 2, 32'hCAFE_F00D, 1'b0);
      do_load(3'b010, 2'd0, 5'd12, 1, 32'hCAFE_F00D, 1'b1);

      do_load(3'b010, 2'd2, 5'd3, 1, 32'h1111_1111, 1'b0);
      do_load(3'b001, 2'd1, 5'd3, 1, 32'h1111_1111, 1'b0);
      do_load(3'b011, 2'd0, 5'd3, 1, 32'h1111_1111, 1'b0);
      do_load(3'b110, 2'd0, 5'd3, 1, 32'h1111_1111, 1'b0);
      step();

      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h7777_7777;
      step();
      bus.mem_rvalid_i = 1'b0;

      do_load(3'b001, 2'd2, 5'd10, 0, 32'h0, 1'b0);
      do_load(3'b010, 2'd0, 5'd11, TIMEOUT, 32'h0BAD_CAFE, 1'b0);
      do_load(3'b000, 2'd1, 5'd13, TIMEOUT + 1, 32'h0000_8000, 1'b0);
      step();

      k = cyc;
      bus.wb_valid_i     = 1'b1;
      bus.wb_sel_i       = 2'd1;
      bus.rd_i           = 5'd4;
      bus.load_funct3_i  = 3'b010;
      bus.load_addr_lo_i = 2'd0;
      set_busy(k + 1);
      set_busy(k + 2);
      step();
      bus.wb_valid_i = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h4444_4444;
      step();
      bus.mem_rvalid_i = 1'b0;
      step();

      wb_op(2'd0, 5'd6, 32'h0F0F_0F0F);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_writeback.md
# reg_writeback

Write-back unit: the write side of the integer register file. Each accepted instruction result (ALU, load data, PC+4 or immediate) is turned into one registered write strobe for the register-file write port. The unit sits between execute/memory and the register file. It aligns and sign-extends load data, suppresses writes to x0, and stalls the front end while a load response is outstanding.

## Interface
- XLEN, 32, data width
- TIMEOUT, 16, maximum cycles to wait for a load response before flagging an error (≥2)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wb_valid_i  in  1  result valid this cycle; sampled only when busy_o=0
- rd_i  in  5  destination register index
- wb_sel_i  in  2  source: 0=ALU, 1=MEM, 2=PC+4, 3=IMM
- alu_res_i  in  XLEN  ALU result
- pc_i  in  XLEN  instruction PC
- imm_i  in  XLEN  decoded immediate
- load_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- load_addr_lo_i  in  2  byte offset of load address
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  XLEN  raw aligned word from data memory
- busy_o  out  1  unit cannot accept; upstream must hold
- rf_we_o  out  1  register-file write strobe, one-cycle pulse
- rf_waddr_o  out  5  write index
- rf_wdata_o  out  XLEN  write data
- err_o  out  1  one-cycle pulse: misaligned load, illegal funct3 or timeout

## Operation
- FSM states: IDLE, WAIT_MEM.
- IDLE, wb_valid_i=1, wb_sel_i≠MEM:
  - Capture data: ALU → alu_res_i, PC+4 → pc_i+4 (mod 2^XLEN), IMM → imm_i.
  - Pulse rf_we_o next cycle.
  - Stay in IDLE.
- IDLE, wb_valid_i=1, wb_sel_i=MEM:
  - Latch rd_i, load_funct3_i and load_addr_lo_i.
  - Clear the timeout counter.
  - Go to WAIT_MEM.
- WAIT_MEM: busy_o=1; counter increments each cycle without mem_rvalid_i.
  - mem_rvalid_i=1: align and extend the data, pulse rf_we_o next cycle, go to IDLE.
  - Counter reaches TIMEOUT-1 with no rvalid: err_o pulse, no write, go to IDLE.
- Load alignment:
  - Byte: byte = rdata[8*lo +: 8]. Zero-extend for LBU, sign-extend for LB.
  - Half: half = rdata[16*lo[1] +: 16]. Zero-extend for LHU, sign-extend for LH.
  - LW passes the word unchanged.
- Errors (checked on acceptance, in IDLE; no WAIT_MEM entry, err_o pulse next cycle, no write):
  - LH/LHU with lo[0]=1.
  - LW with lo≠0.
  - funct3 ∉ {000,001,010,100,101}.
- rd=0: full handshake and state sequence still occur; rf_we_o stays 0.
- mem_rvalid_i in IDLE is ignored.
- wb_valid_i while busy_o=1 is ignored.

## Timing
- Reset values: state=IDLE, busy_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0, counter=0.
- Non-MEM result: rf_we_o/rf_waddr_o/rf_wdata_o valid exactly 1 cycle after acceptance. Back-to-back acceptances give back-to-back writes.
- MEM result:
  - busy_o is combinational from state: high from the cycle after acceptance until the cycle rvalid is sampled, inclusive.
  - Write occurs 1 cycle after mem_rvalid_i.
  - The earliest legal rvalid is 1 cycle after acceptance.
- rvalid in the same cycle the counter reaches TIMEOUT-1: data wins, write occurs, no err_o.
- rf_waddr_o/rf_wdata_o hold their last values when rf_we_o=0.
- rst_i asserted mid-WAIT_MEM: immediate return to IDLE. The pending load is dropped and no write or err_o is produced.

## Structure
- Shared package `wb_pkg`:
  - wb_sel encoding (WB_ALU, WB_MEM, WB_PC4, WB_IMM).
  - Load funct3 constants.
  - FSM state enum.
- Sub-module `load_align`: combinational; inputs funct3, addr_lo, rdata; outputs aligned data and misalign/illegal flag. Also instantiated at acceptance for the error check.

## Test plan
- ALU write: wb_valid_i=1, sel=ALU, rd=5, alu_res=0x1234_5678 → next cycle rf_we_o=1, waddr=5, wdata=0x1234_5678; following cycle rf_we_o=0.
- x0 suppression: sel=IMM, rd=0, imm=0xFFFF_FFFF → rf_we_o stays 0 for all cycles, busy_o stays 0.
- Load extension: LB, lo=3, rd=7, rvalid 2 cycles later with rdata=0x80AA_BBCC → busy_o high 2 cycles; write waddr=7, wdata=0xFFFF_FF80. Repeat with LBU → wdata=0x0000_0080.
- Misaligned: LW with lo=2 → err_o pulse 1 cycle after acceptance; no write; busy_o never asserted.
- Timeout: LH with lo=2, TIMEOUT=16, no rvalid → busy_o high 16 cycles, err_o pulse, no write. Boundary run: rvalid at counter 15 → write occurs, no err_o.
- Reset mid-load: accept LW, assert rst_i 3 cycles later, then rvalid → busy_o=0 immediately, no rf_we_o, no err_o.
